// File: rtl/ahb_lite_arb2.sv
// ---------------------------------------------------------------------------
// ahb_lite_arb2
//   Two-master to one-slave AHB-Lite arbiter. Master 0 (CPU side) and
//   master 1 (DMA side) share one slave port (SDRAM controller).
//   Ownership only changes at transaction boundaries: while the current
//   owner drives a non-IDLE transfer or holds HMASTLOCK, the other master
//   is stalled through its HREADYOUT and keeps its address on the bus.
//
// Ports
//   HCLK, HRESET            clock, synchronous active-high reset
//   M0_*/M1_* (in)          master request side: HSEL, HADDR, HTRANS, HWRITE,
//                           HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
//   M0_*/M1_* (out)         HRDATA (broadcast), HREADYOUT, HRESP
//   S_* (out)               muxed address/control/write data to the slave,
//                           S_HREADY = S_HREADYOUT
//   S_HRDATA/HREADYOUT/HRESP (in)  slave response
//   owner                   current address-phase owner
// ---------------------------------------------------------------------------
module ahb_lite_arb2 #(
  parameter int PARK_MASTER = 0,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  // master 0
  input  logic          M0_HSEL,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [1:0]    M0_HTRANS,
  input  logic          M0_HWRITE,
  input  logic [2:0]    M0_HSIZE,
  input  logic [2:0]    M0_HBURST,
  input  logic [3:0]    M0_HPROT,
  input  logic          M0_HMASTLOCK,
  input  logic [DW-1:0] M0_HWDATA,
  output logic [DW-1:0] M0_HRDATA,
  output logic          M0_HREADYOUT,
  output logic          M0_HRESP,
  // master 1
  input  logic          M1_HSEL,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [1:0]    M1_HTRANS,
  input  logic          M1_HWRITE,
  input  logic [2:0]    M1_HSIZE,
  input  logic [2:0]    M1_HBURST,
  input  logic [3:0]    M1_HPROT,
  input  logic          M1_HMASTLOCK,
  input  logic [DW-1:0] M1_HWDATA,
  output logic [DW-1:0] M1_HRDATA,
  output logic          M1_HREADYOUT,
  output logic          M1_HRESP,
  // slave
  output logic          S_HSEL,
  output logic [AW-1:0] S_HADDR,
  output logic [1:0]    S_HTRANS,
  output logic          S_HWRITE,
  output logic [2:0]    S_HSIZE,
  output logic [2:0]    S_HBURST,
  output logic [3:0]    S_HPROT,
  output logic          S_HMASTLOCK,
  output logic [DW-1:0] S_HWDATA,
  output logic          S_HREADY,
  input  logic [DW-1:0] S_HRDATA,
  input  logic          S_HREADYOUT,
  input  logic          S_HRESP,
  // debug
  output logic          owner
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic       PARK          = (PARK_MASTER != 0);

  // Master inputs gathered into arrays so the mux can index by master id.
  logic          m_hsel   [2];
  logic [AW-1:0] m_haddr  [2];
  logic [1:0]    m_htrans [2];
  logic          m_hwrite [2];
  logic [2:0]    m_hsize  [2];
  logic [2:0]    m_hburst [2];
  logic [3:0]    m_hprot  [2];
  logic          m_hlock  [2];
  logic [DW-1:0] m_hwdata [2];
  logic          m_hready [2];

  assign m_hsel   = '{M0_HSEL,      M1_HSEL};
  assign m_haddr  = '{M0_HADDR,     M1_HADDR};
  assign m_htrans = '{M0_HTRANS,    M1_HTRANS};
  assign m_hwrite = '{M0_HWRITE,    M1_HWRITE};
  assign m_hsize  = '{M0_HSIZE,     M1_HSIZE};
  assign m_hburst = '{M0_HBURST,    M1_HBURST};
  assign m_hprot  = '{M0_HPROT,     M1_HPROT};
  assign m_hlock  = '{M0_HMASTLOCK, M1_HMASTLOCK};
  assign m_hwdata = '{M0_HWDATA,    M1_HWDATA};

  logic owner_q, owner_d;
  logic dact_q,  dact_d;
  logic owner_eff, dact_eff, other, sel;

  // NOTE: reset is synchronous, so the registers may not yet hold their reset
  // values in the first reset cycle; outputs are derived from the reset state
  // directly while HRESET is high so the bus is well defined from time zero.
  assign owner_eff = HRESET ? PARK : owner_q;
  assign dact_eff  = HRESET ? 1'b0 : dact_q;
  assign other     = ~owner_eff;

  // Address-phase grant: hand over only when the slave is ready, the owner
  // is IDLE and unlocked, and the other master starts a new transfer. The
  // handover is combinational, so no dead cycle is inserted.
  always_comb begin
    sel = owner_eff;
    if (!HRESET && S_HREADYOUT &&
        m_htrans[owner_eff] == HTRANS_IDLE && !m_hlock[owner_eff] &&
        m_hsel[other] && m_htrans[other] == HTRANS_NONSEQ)
      sel = other;
  end

  // Registers advance only on a completed transfer (S_HREADYOUT high).
  always_comb begin
    owner_d = owner_q;
    dact_d  = dact_q;
    if (S_HREADYOUT) begin
      owner_d = sel;
      dact_d  = m_hsel[sel] && m_htrans[sel][1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q <= PARK;
      dact_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      dact_q  <= dact_d;
    end
  end

  // HREADYOUT per master: the selected master and the data-phase owner see
  // the slave's ready; a losing master with a pending NONSEQ is stalled.
  always_comb begin
    m_hready[0] = 1'b1;
    m_hready[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (sel == 1'(i) || owner_eff == 1'(i))
        m_hready[i] = S_HREADYOUT;
      else if (m_hsel[i] && m_htrans[i] == HTRANS_NONSEQ)
        m_hready[i] = 1'b0;
    end
  end

  // Slave side: address/control from the address winner, write data from
  // the data-phase owner (the previous cycle's winner).
  assign S_HSEL      = m_hsel[sel];
  assign S_HADDR     = m_haddr[sel];
  assign S_HTRANS    = m_hsel[sel] ? m_htrans[sel] : HTRANS_IDLE;
  assign S_HWRITE    = m_hwrite[sel];
  assign S_HSIZE     = m_hsize[sel];
  assign S_HBURST    = m_hburst[sel];
  assign S_HPROT     = m_hprot[sel];
  assign S_HMASTLOCK = m_hlock[sel];
  assign S_HWDATA    = m_hwdata[owner_eff];
  assign S_HREADY    = S_HREADYOUT;

  // Master side: read data is broadcast; the response only goes to the
  // master that owns an active data phase.
  assign M0_HRDATA    = S_HRDATA;
  assign M1_HRDATA    = S_HRDATA;
  assign M0_HREADYOUT = m_hready[0];
  assign M1_HREADYOUT = m_hready[1];
  assign M0_HRESP     = S_HRESP && dact_eff && (owner_eff == 1'b0);
  assign M1_HRESP     = S_HRESP && dact_eff && (owner_eff == 1'b1);

  assign owner = owner_eff;

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_arb2
//   Directed bench for ahb_lite_arb2 (PARK_MASTER=0). Inputs are driven 1ns
//   after the rising edge, outputs are sampled on the falling edge. The slave
//   response is driven directly from the stimulus.
// ---------------------------------------------------------------------------
module tb_ahb_lite_arb2;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] INCR4  = 3'b011;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          M0_HSEL, M1_HSEL;
  logic [AW-1:0] M0_HADDR, M1_HADDR;
  logic [1:0]    M0_HTRANS, M1_HTRANS;
  logic          M0_HWRITE, M1_HWRITE;
  logic [2:0]    M0_HSIZE, M1_HSIZE;
  logic [2:0]    M0_HBURST, M1_HBURST;
  logic [3:0]    M0_HPROT, M1_HPROT;
  logic          M0_HMASTLOCK, M1_HMASTLOCK;
  logic [DW-1:0] M0_HWDATA, M1_HWDATA;
  logic [DW-1:0] M0_HRDATA, M1_HRDATA;
  logic          M0_HREADYOUT, M1_HREADYOUT;
  logic          M0_HRESP, M1_HRESP;
  logic          S_HSEL;
  logic [AW-1:0] S_HADDR;
  logic [1:0]    S_HTRANS;
  logic          S_HWRITE;
  logic [2:0]    S_HSIZE;
  logic [2:0]    S_HBURST;
  logic [3:0]    S_HPROT;
  logic          S_HMASTLOCK;
  logic [DW-1:0] S_HWDATA;
  logic          S_HREADY;
  logic [DW-1:0] S_HRDATA;
  logic          S_HREADYOUT;
  logic          S_HRESP;
  logic          owner;

  int checks = 0;
  int errors = 0;

  ahb_lite_arb2 #(.PARK_MASTER(0), .AW(AW), .DW(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
    .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST),
    .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
    .M0_HRDATA(M0_HRDATA), .M0_HREADYOUT(M0_HREADYOUT), .M0_HRESP(M0_HRESP),
    .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
    .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST),
    .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
    .M1_HRDATA(M1_HRDATA), .M1_HREADYOUT(M1_HREADYOUT), .M1_HRESP(M1_HRESP),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS),
    .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST),
    .S_HPROT(S_HPROT), .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA),
    .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT),
    .S_HRESP(S_HRESP), .owner(owner)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_idle();
    M0_HSEL = 1'b0; M0_HADDR = '0; M0_HTRANS = IDLE; M0_HWRITE = 1'b0;
    M0_HSIZE = 3'b010; M0_HBURST = 3'b000; M0_HPROT = 4'h3;
    M0_HMASTLOCK = 1'b0; M0_HWDATA = '0;
    M1_HSEL = 1'b0; M1_HADDR = '0; M1_HTRANS = IDLE; M1_HWRITE = 1'b0;
    M1_HSIZE = 3'b010; M1_HBURST = 3'b000; M1_HPROT = 4'h3;
    M1_HMASTLOCK = 1'b0; M1_HWDATA = '0;
    S_HRDATA = '0; S_HREADYOUT = 1'b1; S_HRESP = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    // In reset: M1 requests, M0 parked and IDLE -> M1 stalled, bus idle.
    M0_HSEL = 1'b1; M0_HTRANS = IDLE;
    M1_HSEL = 1'b1; M1_HTRANS = NONSEQ; M1_HADDR = 32'h300;
    @(negedge HCLK);
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b exp 0", owner); end
    checks++; if (S_HTRANS !== IDLE) begin errors++; $display("FAIL rst_htrans: got %b exp 00", S_HTRANS); end
    checks++; if (M0_HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_m0_ready: got %b exp 1", M0_HREADYOUT); end
    checks++; if (M1_HREADYOUT !== 1'b0) begin errors++; $display("FAIL rst_m1_ready: got %b exp 0", M1_HREADYOUT); end
    next_cycle();
    drive_idle();
    HRESET = 1'b0;
    @(negedge HCLK);
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL post_rst_owner: got %b exp 0", owner); end
    checks++; if (S_HSEL !== 1'b0) begin errors++; $display("FAIL post_rst_hsel: got %b exp 0", S_HSEL); end
    next_cycle();
  endtask

  task automatic test_single_write();
    M0_HSEL = 1'b1; M0_HADDR = 32'h100; M0_HTRANS = NONSEQ; M0_HWRITE = 1'b1;
    @(negedge HCLK);
    checks++; if (S_HADDR !== 32'h100) begin errors++; $display("FAIL sw_haddr: got %h exp 00000100", S_HADDR); end
    checks++; if (S_HTRANS !== NONSEQ) begin errors++; $display("FAIL sw_htrans: got %b exp 10", S_HTRANS); end
    checks++; if (S_HWRITE !== 1'b1) begin errors++; $display("FAIL sw_hwrite: got %b exp 1", S_HWRITE); end
    checks++; if (M1_HREADYOUT !== 1'b1) begin errors++; $display("FAIL sw_m1_ready_a: got %b exp 1", M1_HREADYOUT); end
    next_cycle();
    M0_HTRANS = IDLE; M0_HWDATA = 32'hA5A5A5A5;
    @(negedge HCLK);
    checks++; if (S_HWDATA !== 32'hA5A5A5A5) begin errors++; $display("FAIL sw_hwdata: got %h exp a5a5a5a5", S_HWDATA); end
    checks++; if (S_HTRANS !== IDLE) begin errors++; $display("FAIL sw_idle: got %b exp 00", S_HTRANS); end
    checks++; if (M1_HREADYOUT !== 1'b1) begin errors++; $display("FAIL sw_m1_ready_d: got %b exp 1", M1_HREADYOUT); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_burst_handover();
    logic [AW-1:0] beat_addr [4];
    logic [DW-1:0] beat_data [4];
    beat_addr = '{32'h200, 32'h204, 32'h208, 32'h20C};
    beat_data = '{32'hD0D0_0000, 32'hD1D1_1111, 32'hD2D2_2222, 32'hD3D3_3333};
    M0_HSEL = 1'b1; M0_HWRITE = 1'b1; M0_HBURST = INCR4;
    for (int b = 0; b < 4; b++) begin
      M0_HADDR  = beat_addr[b];
      M0_HTRANS = (b == 0) ? NONSEQ : SEQ;
      if (b > 0) M0_HWDATA = beat_data[b-1];
      if (b == 1) begin
        M1_HSEL = 1'b1; M1_HADDR = 32'h300; M1_HTRANS = NONSEQ; M1_HWRITE = 1'b1;
      end
      @(negedge HCLK);
      checks++; if (S_HADDR !== beat_addr[b]) begin errors++; $display("FAIL bh_addr%0d: got %h exp %h", b, S_HADDR, beat_addr[b]); end
      if (b > 0) begin
        checks++; if (S_HWDATA !== beat_data[b-1]) begin errors++; $display("FAIL bh_wdata%0d: got %h exp %h", b, S_HWDATA, beat_data[b-1]); end
        checks++; if (M1_HREADYOUT !== 1'b0) begin errors++; $display("FAIL bh_m1_stall%0d: got %b exp 0", b, M1_HREADYOUT); end
      end
      next_cycle();
    end
    // M0 goes IDLE with its last data beat: M1 gets the address same cycle.
    M0_HTRANS = IDLE; M0_HWDATA = beat_data[3];
    @(negedge HCLK);
    checks++; if (S_HADDR !== 32'h300) begin errors++; $display("FAIL bh_m1_addr: got %h exp 00000300", S_HADDR); end
    checks++; if (S_HTRANS !== NONSEQ) begin errors++; $display("FAIL bh_m1_trans: got %b exp 10", S_HTRANS); end
    checks++; if (M1_HREADYOUT !== 1'b1) begin errors++; $display("FAIL bh_m1_ready: got %b exp 1", M1_HREADYOUT); end
    checks++; if (S_HWDATA !== beat_data[3]) begin errors++; $display("FAIL bh_last_beat: got %h exp %h", S_HWDATA, beat_data[3]); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL bh_owner_pre: got %b exp 0", owner); end
    next_cycle();
    drive_idle();
    M1_HSEL = 1'b1; M1_HWDATA = 32'h3333_3333;
    @(negedge HCLK);
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL bh_owner_post: got %b exp 1", owner); end
    checks++; if (S_HWDATA !== 32'h3333_3333) begin errors++; $display("FAIL bh_m1_wdata: got %h exp 33333333", S_HWDATA); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_wait_states();
    // owner is 1 and idle; M0 read takes the bus immediately.
    M0_HSEL = 1'b1; M0_HADDR = 32'h400; M0_HTRANS = NONSEQ; M0_HWRITE = 1'b0;
    @(negedge HCLK);
    checks++; if (S_HADDR !== 32'h400) begin errors++; $display("FAIL ws_addr: got %h exp 00000400", S_HADDR); end
    next_cycle();
    M0_HTRANS = IDLE;
    M1_HSEL = 1'b1; M1_HADDR = 32'h500; M1_HTRANS = NONSEQ;
    S_HREADYOUT = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge HCLK);
      checks++; if (owner !== 1'b0) begin errors++; $display("FAIL ws_owner%0d: got %b exp 0", w, owner); end
      checks++; if (M1_HREADYOUT !== 1'b0) begin errors++; $display("FAIL ws_m1_stall%0d: got %b exp 0", w, M1_HREADYOUT); end
      checks++; if (M0_HREADYOUT !== 1'b0) begin errors++; $display("FAIL ws_m0_wait%0d: got %b exp 0", w, M0_HREADYOUT); end
      next_cycle();
    end
    S_HREADYOUT = 1'b1; S_HRDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    checks++; if (M0_HRDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws_rdata: got %h exp deadbeef", M0_HRDATA); end
    checks++; if (M0_HREADYOUT !== 1'b1) begin errors++; $display("FAIL ws_m0_done: got %b exp 1", M0_HREADYOUT); end
    checks++; if (S_HADDR !== 32'h500) begin errors++; $display("FAIL ws_m1_addr: got %h exp 00000500", S_HADDR); end
    next_cycle();
    drive_idle();
    next_cycle();
  endtask

  task automatic test_lock();
    // owner is 1. Two locked transfers then a locked IDLE hold off M0.
    logic [AW-1:0] lk_addr [2];
    lk_addr = '{32'h600, 32'h604};
    M0_HSEL = 1'b1; M0_HADDR = 32'h700; M0_HTRANS = NONSEQ;
    M1_HSEL = 1'b1; M1_HMASTLOCK = 1'b1; M1_HWRITE = 1'b1; M1_HTRANS = NONSEQ;
    for (int t = 0; t < 2; t++) begin
      M1_HADDR = lk_addr[t];
      @(negedge HCLK);
      checks++; if (S_HADDR !== lk_addr[t]) begin errors++; $display("FAIL lk_addr%0d: got %h exp %h", t, S_HADDR, lk_addr[t]); end
      checks++; if (M0_HREADYOUT !== 1'b0) begin errors++; $display("FAIL lk_m0_stall%0d: got %b exp 0", t, M0_HREADYOUT); end
      next_cycle();
    end
    M1_HTRANS = IDLE;
    @(negedge HCLK);
    checks++; if (M0_HREADYOUT !== 1'b0) begin errors++; $display("FAIL lk_idle_stall: got %b exp 0", M0_HREADYOUT); end
    checks++; if (S_HMASTLOCK !== 1'b1) begin errors++; $display("FAIL lk_lock: got %b exp 1", S_HMASTLOCK); end
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL lk_owner: got %b exp 1", owner); end
    next_cycle();
    M1_HMASTLOCK = 1'b0;
    @(negedge HCLK);
    checks++; if (S_HADDR !== 32'h700) begin errors++; $display("FAIL lk_m0_addr: got %h exp 00000700", S_HADDR); end
    checks++; if (M0_HREADYOUT !== 1'b1) begin errors++; $display("FAIL lk_m0_ready: got %b exp 1", M0_HREADYOUT); end
    next_cycle();
    drive_idle();
    @(negedge HCLK);
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL lk_owner_post: got %b exp 0", owner); end
    next_cycle();
  endtask

  task automatic test_error();
    M1_HSEL = 1'b1; M1_HADDR = 32'h800; M1_HTRANS = NONSEQ; M1_HWRITE = 1'b1;
    next_cycle();
    M1_HTRANS = IDLE;
    S_HREADYOUT = 1'b0; S_HRESP = 1'b1;
    @(negedge HCLK);
    checks++; if (M1_HRESP !== 1'b1) begin errors++; $display("FAIL er_resp1: got %b exp 1", M1_HRESP); end
    checks++; if (M1_HREADYOUT !== 1'b0) begin errors++; $display("FAIL er_ready1: got %b exp 0", M1_HREADYOUT); end
    checks++; if (M0_HRESP !== 1'b0) begin errors++; $display("FAIL er_m0_resp1: got %b exp 0", M0_HRESP); end
    next_cycle();
    S_HREADYOUT = 1'b1;
    @(negedge HCLK);
    checks++; if (M1_HRESP !== 1'b1) begin errors++; $display("FAIL er_resp2: got %b exp 1", M1_HRESP); end
    checks++; if (M1_HREADYOUT !== 1'b1) begin errors++; $display("FAIL er_ready2: got %b exp 1", M1_HREADYOUT); end
    checks++; if (M0_HRESP !== 1'b0) begin errors++; $display("FAIL er_m0_resp2: got %b exp 0", M0_HRESP); end
    next_cycle();
    S_HRESP = 1'b0;
    @(negedge HCLK);
    checks++; if (M1_HRESP !== 1'b0) begin errors++; $display("FAIL er_resp_end: got %b exp 0", M1_HRESP); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_reset_mid_burst();
    // owner is 1. Start an M1 INCR4 burst, then reset on beat 2.
    M1_HSEL = 1'b1; M1_HADDR = 32'h900; M1_HTRANS = NONSEQ; M1_HBURST = INCR4;
    next_cycle();
    M1_HADDR = 32'h904; M1_HTRANS = SEQ;
    M0_HSEL = 1'b1; M0_HADDR = 32'hA00; M0_HTRANS = NONSEQ;
    HRESET = 1'b1;
    @(negedge HCLK);
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rm_owner_rst: got %b exp 0", owner); end
    checks++; if (S_HADDR !== 32'hA00) begin errors++; $display("FAIL rm_addr_rst: got %h exp 00000a00", S_HADDR); end
    checks++; if (M1_HREADYOUT !== 1'b1) begin errors++; $display("FAIL rm_m1_seq: got %b exp 1", M1_HREADYOUT); end
    next_cycle();
    HRESET = 1'b0;
    M1_HADDR = 32'h900; M1_HTRANS = NONSEQ;
    S_HRESP = 1'b1;  // dact_q cleared by reset, so no master may see it
    @(negedge HCLK);
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rm_owner: got %b exp 0", owner); end
    checks++; if (M1_HREADYOUT !== 1'b0) begin errors++; $display("FAIL rm_m1_stall: got %b exp 0", M1_HREADYOUT); end
    checks++; if (M0_HRESP !== 1'b0) begin errors++; $display("FAIL rm_dact: got %b exp 0", M0_HRESP); end
    checks++; if (S_HADDR !== 32'hA00) begin errors++; $display("FAIL rm_m0_addr: got %h exp 00000a00", S_HADDR); end
    next_cycle();
    S_HRESP = 1'b0;
    M0_HTRANS = IDLE;
    @(negedge HCLK);
    checks++; if (M1_HREADYOUT !== 1'b1) begin errors++; $display("FAIL rm_m1_go: got %b exp 1", M1_HREADYOUT); end
    checks++; if (S_HADDR !== 32'h900) begin errors++; $display("FAIL rm_m1_addr: got %h exp 00000900", S_HADDR); end
    next_cycle();
    drive_idle();
    @(negedge HCLK);
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL rm_owner_end: got %b exp 1", owner); end
    next_cycle();
  endtask

  initial begin
    drive_idle();
    HRESET = 1'b1;
    next_cycle();
    test_reset();
    test_single_write();
    test_burst_handover();
    test_wait_states();
    test_lock();
    test_error();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
